// File: rtl/mcu_spi_responder.sv
// Mode-0 SPI responder (MISO only): snapshots the latest x/y samples into a
// 40-bit frame on chip-select and shifts it out MSB first, oversampled in clk.
module mcu_spi_responder #(
   parameter int DW          = 16,
   parameter int SEQW        = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sample_valid,
   input  logic [DW-1:0] x_sample,
   input  logic [DW-1:0] y_sample,
   input  logic          spi_sclk,
   input  logic          spi_cs_n,
   output logic          spi_miso,
   output logic          spi_miso_oe,
   output logic          frame_done,
   output logic          frame_abort
);

   localparam int FW = 1 + SEQW + 2 * DW;
   localparam int CW = $clog2(FW + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t               state, state_nxt;
   logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, warm;
   logic                 cs_d, sclk_d, cs_s, sclk_s;
   logic                 cs_fall, cs_rise, sclk_rise, sclk_fall;
   logic                 armed;
   logic [DW-1:0]        x_shadow, y_shadow;
   logic [SEQW-1:0]      seq;
   logic                 new_flag;
   logic [FW-1:0]        shreg, shreg_nxt, frame;
   logic [CW-1:0]        bit_cnt, bit_cnt_nxt;
   logic                 load, done_nxt, abort_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync   <= '1;
         sclk_sync <= '0;
         cs_d      <= 1'b1;
         sclk_d    <= 1'b0;
         warm      <= '0;
      end else begin
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         cs_d      <= cs_s;
         sclk_d    <= sclk_s;
         warm      <= {warm[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_fall   = cs_d & ~cs_s;
   assign cs_rise   = ~cs_d & cs_s;
   assign sclk_rise = ~sclk_d & sclk_s;
   assign sclk_fall = sclk_d & ~sclk_s;

   // The reset-value 1s in the cs_n chain are not a real observation of an
   // idle bus; wait until the chain holds only post-reset samples before arming.
   always_ff @(posedge clk) begin
      if (rst)
         armed <= 1'b0;
      else if (warm[SYNC_STAGES-1] && cs_s)
         armed <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_shadow <= '0;
         y_shadow <= '0;
         seq      <= '0;
         new_flag <= 1'b0;
      end else if (sample_valid) begin
         x_shadow <= x_sample;
         y_shadow <= y_sample;
         seq      <= seq + 1'b1;
         new_flag <= 1'b1;
      end else if (load) begin
         new_flag <= 1'b0;
      end
   end

   assign frame = {new_flag, seq, x_shadow, y_shadow};

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         state       <= state_nxt;
         shreg       <= shreg_nxt;
         bit_cnt     <= bit_cnt_nxt;
         frame_done  <= done_nxt;
         frame_abort <= abort_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      load        = 1'b0;
      done_nxt    = 1'b0;
      abort_nxt   = 1'b0;
      if (cs_rise) begin
         state_nxt = IDLE;
         done_nxt  = (state == DONE);
         abort_nxt = (state == SHIFT);
      end else begin
         case (state)
            IDLE: begin
               if (cs_fall && armed) begin
                  load        = 1'b1;
                  shreg_nxt   = frame;
                  bit_cnt_nxt = '0;
                  state_nxt   = SHIFT;
               end
            end
            SHIFT: begin
               if (sclk_rise) begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
                  if (bit_cnt == CW'(FW - 1))
                     state_nxt = DONE;
               end else if (sclk_fall && (bit_cnt < CW'(FW))) begin
                  shreg_nxt = {shreg[FW-2:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
      spi_miso    = (state == SHIFT) & shreg[FW-1];
      spi_miso_oe = (state != IDLE);
   end

endmodule

// File: tb/tb_mcu_spi_responder.sv
// Directed bench for mcu_spi_responder: mode-0 reads with sclk = clk/16,
// inputs driven and outputs sampled on the falling edge of clk.
module tb_mcu_spi_responder;

   logic        clk = 1'b0;
   logic        rst, sample_valid, spi_sclk, spi_cs_n;
   logic [15:0] x_sample, y_sample;
   logic        spi_miso, spi_miso_oe, frame_done, frame_abort;
   int          tests = 0;
   int          fails = 0;

   mcu_spi_responder #(.DW(16), .SEQW(7), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid),
      .x_sample(x_sample), .y_sample(y_sample),
      .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .frame_done(frame_done), .frame_abort(frame_abort)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse(input logic [15:0] ix, input logic [15:0] iy);
      sample_valid = 1'b1; x_sample = ix; y_sample = iy;
      tick();
      sample_valid = 1'b0;
   endtask

   // inj < 0: sample lands on the synchronized cs_fall cycle; inj >= 0: during bit inj
   task automatic spi_read(input int nbits, input int inj, input logic [15:0] ix,
                           input logic [15:0] iy, output logic [39:0] data,
                           output int oe_bad, output logic tail_miso, output logic tail_oe,
                           output int n_done, output int n_abort, output logic oe_after);
      data = '0; oe_bad = 0; n_done = 0; n_abort = 0;
      spi_cs_n = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (inj < 0 && k == 2) begin
            sample_valid = 1'b1; x_sample = ix; y_sample = iy;
         end
         tick();
         sample_valid = 1'b0;
      end
      for (int i = 0; i < nbits; i++) begin
         data = {data[38:0], spi_miso};
         if (spi_miso_oe !== 1'b1) oe_bad++;
         spi_sclk = 1'b1;
         if (i == inj) begin
            sample_valid = 1'b1; x_sample = ix; y_sample = iy;
         end
         tick();
         sample_valid = 1'b0;
         repeat (7) tick();
         spi_sclk = 1'b0;
         repeat (8) tick();
      end
      tail_miso = spi_miso;
      tail_oe   = spi_miso_oe;
      spi_cs_n  = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (frame_done === 1'b1)  n_done++;
         if (frame_abort === 1'b1) n_abort++;
      end
      oe_after = spi_miso_oe;
      repeat (4) tick();
   endtask

   task automatic full_read(input string tag, input logic [39:0] exp, input int inj,
                            input logic [15:0] ix, input logic [15:0] iy);
      logic [39:0] d;
      int          ob, nd, na;
      logic        tm, toe, oa;
      spi_read(40, inj, ix, iy, d, ob, tm, toe, nd, na, oa);
      check({tag, "_data"}, d, exp);
      check({tag, "_oe_during"}, ob, 0);
      check({tag, "_done_miso"}, tm, 1'b0);
      check({tag, "_done_oe"}, toe, 1'b1);
      check({tag, "_frame_done"}, nd, 1);
      check({tag, "_frame_abort"}, na, 0);
      check({tag, "_oe_after"}, oa, 1'b0);
   endtask

   initial begin
      logic [39:0] d;
      int          ob, nd, na, act;
      logic        tm, toe, oa;

      rst = 1'b1; sample_valid = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1;
      x_sample = '0; y_sample = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_miso", spi_miso, 1'b0);
      check("rst_oe", spi_miso_oe, 1'b0);
      check("rst_done", frame_done, 1'b0);
      check("rst_abort", frame_abort, 1'b0);
      repeat (4) tick();

      pulse(16'hA5C3, 16'h0F0F);
      full_read("rd1", {8'h81, 16'hA5C3, 16'h0F0F}, 99, 16'h0, 16'h0);
      full_read("rd2", {8'h01, 16'hA5C3, 16'h0F0F}, 99, 16'h0, 16'h0);

      // new sample while shifting: current frame unaffected
      full_read("mid", {8'h01, 16'hA5C3, 16'h0F0F}, 10, 16'h1234, 16'h5678);
      full_read("mid_next", {8'h82, 16'h1234, 16'h5678}, 99, 16'h0, 16'h0);

      // new sample on the same cycle the frame is loaded
      full_read("coin", {8'h02, 16'h1234, 16'h5678}, -1, 16'hBEEF, 16'hCAFE);
      full_read("coin_next", {8'h83, 16'hBEEF, 16'hCAFE}, 99, 16'h0, 16'h0);

      // abort after 17 bits
      spi_read(17, 99, 16'h0, 16'h0, d, ob, tm, toe, nd, na, oa);
      check("abort_bits", d[16:0], 17'b0000_0011_1011_1110_1);
      check("abort_pulse", na, 1);
      check("abort_no_done", nd, 0);
      check("abort_oe_after", oa, 1'b0);
      full_read("post_abort", {8'h03, 16'hBEEF, 16'hCAFE}, 99, 16'h0, 16'h0);

      // reset with cs_n held low mid-frame
      spi_cs_n = 1'b0;
      repeat (8) tick();
      for (int i = 0; i < 5; i++) begin
         spi_sclk = 1'b1; repeat (8) tick();
         spi_sclk = 1'b0; repeat (8) tick();
      end
      rst = 1'b1;
      tick();
      check("rst_mid_oe_next", spi_miso_oe, 1'b0);
      tick();
      rst = 1'b0;
      act = 0;
      for (int i = 0; i < 6; i++) begin
         spi_sclk = 1'b1;
         repeat (8) begin
            tick();
            if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0 || frame_done !== 1'b0 || frame_abort !== 1'b0) act++;
         end
         spi_sclk = 1'b0;
         repeat (8) begin
            tick();
            if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0 || frame_done !== 1'b0 || frame_abort !== 1'b0) act++;
         end
      end
      spi_cs_n = 1'b1;
      repeat (10) begin
         tick();
         if (spi_miso_oe !== 1'b0 || frame_done !== 1'b0 || frame_abort !== 1'b0) act++;
      end
      check("rst_mid_quiet", act, 0);
      full_read("post_rst", 40'h00_0000_0000, 99, 16'h0, 16'h0);

      // sequence counter wrap
      for (int i = 0; i < 128; i++) pulse(16'(i), ~16'(i));
      full_read("wrap128", {8'h80, 16'h007F, 16'hFF80}, 99, 16'h0, 16'h0);
      pulse(16'h1111, 16'h2222);
      full_read("wrap129", {8'h81, 16'h1111, 16'h2222}, 99, 16'h0, 16'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
